mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data-memory interface. Sits between the datapath and the
//  data memory: accepts byte/half/word load and store requests over a valid/ready
//  handshake and drives address, write data, read and write strobes to the memory.
//  Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
//  Misaligned or out-of-range requests are flagged and never reach memory.
// PARAMETERS
//  ADDR_W      32         width of req_addr / mem_adr
//  ADDR_LIMIT  32'h10000  first illegal byte address; req_addr >= limit -> error
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       unit can accept; high only in IDLE
//  req_write    in   1       1 = store, 0 = load
//  req_size     in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1       load zero-extend (1) / sign-extend (0)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data; low byte/half used for sub-word
//  resp_valid   out  1       one-cycle completion pulse; no backpressure
//  resp_err     out  1       valid with resp_valid: misaligned/illegal/out of range
//  resp_rdata   out  32      load result; 0 for stores and errors
//  mem_adr      out  ADDR_W  word-aligned address {req_addr[W-1:2],2'b00}
//  mem_wdata    out  32      word written to memory
//  mem_read     out  1       read strobe; mem_rdata valid combinationally
//  mem_write    out  1       write strobe; memory writes on posedge clk
//  mem_rdata    in   32      little-endian word read from memory
// BEHAVIOUR
//  - Reset (async): state IDLE, req_ready=1, all other outputs and captured regs 0.
//    mem_read/mem_write decode from state, so they drop immediately on reset.
//  - Accept when req_valid & req_ready at posedge. Latch addr/size/write/unsigned/wdata.
//  - States: IDLE, LOAD, RMW_RD, WRITE, RESP.
//    IDLE -accept-> error? RESP : load? LOAD : word store? WRITE : RMW_RD.
//    LOAD: mem_read=1, extract lane, extend, register into rdata; -> RESP.
//    RMW_RD: mem_read=1, register merged word (new lane replaces old); -> WRITE.
//    WRITE: mem_write=1, mem_wdata=merged or full word; -> RESP.
//    RESP: resp_valid=1 for exactly one cycle; -> IDLE.
//  - Latency from accept edge to resp_valid: load 2, word store 2,
//    sub-word store 3, error 1 cycle(s).
//  - Lane select: byte lane = addr[1:0]; half lane = addr[1] (bits [15:0] or [31:16]).
//  - Errors: size=11; half with addr[0]=1; word with addr[1:0]!=0;
//    addr+bytes > ADDR_LIMIT. resp_err=1, resp_rdata=0, no mem strobe raised.
//  - mem_adr is driven only in LOAD/RMW_RD/WRITE; 0 otherwise.
//  - mem_wdata is 0 outside WRITE.
//  - mem_read and mem_write are never high together.
//  - req_valid while busy is ignored; the request is not queued.
//  - Requester must hold the request until accepted.
//  - Reset during RMW_RD or WRITE aborts; no write occurs on later edges.
// TESTING
//  1. Store word 0x11223344 @0x10, load word @0x10 -> resp_rdata=0x11223344, err=0,
//     resp_valid 2 cycles after each accept.
//  2. Byte store 0xAB @0x11 over 0x11223344 -> mem_wdata=0x1122AB44 in WRITE;
//     exactly one mem_read cycle, then one mem_write cycle.
//  3. Mem word 0x00008000: byte load signed @0x01 -> 0xFFFFFF80; unsigned -> 0x00000080;
//     half load signed @0x00 -> 0xFFFF8000.
//  4. Half store @0x13, word load @0x12, size=11, word @ADDR_LIMIT
//     -> resp_err=1 one cycle after accept, mem_read=mem_write=0 throughout.
//  5. Assert rst while in WRITE -> mem_write low same cycle, memory word unchanged,
//     req_ready=1 after release.
//  6. Hold req_valid with changing addr during a busy load -> single response only;
//     next request accepted the cycle after resp_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: datapath-to-data-memory initiator.
// Byte/half/word loads and stores, RMW for sub-word stores.
module mem_access_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h10000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [31:0]       wbuf_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              bad;

  logic [7:0]        lane8;
  logic [15:0]       lane16;
  logic [31:0]       ld_val;
  logic [31:0]       merged;

  assign accept = req_valid & req_ready;

  // Legality of the incoming request: size, alignment, range.
  always_comb begin
    unique case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr = {1'b0, req_addr}
             + {{(ADDR_W-2){1'b0}}, nbytes};
    bad = (req_size == 2'b11)
        | ((req_size == 2'b01) & req_addr[0])
        | ((req_size == 2'b10) & (|req_addr[1:0]))
        | (end_addr > {1'b0, ADDR_LIMIT});
  end

  // Lane extraction for loads and lane merge for RMW.
  always_comb begin
    lane8  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane16 = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:
        ld_val = uns_q ? {24'h0, lane8}
                       : {{24{lane8[7]}}, lane8};
      2'b01:
        ld_val = uns_q ? {16'h0, lane16}
                       : {{16{lane16[15]}}, lane16};
      default:
        ld_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and state-decoded strobes.
  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                  nxt = RESP;
          else if (!req_write)      nxt = LOAD;
          else if (req_size == 2'b10) nxt = WRITE;
          else                      nxt = RMW_RD;
        end
      end
      LOAD: begin
        mem_read = 1'b1;
        nxt      = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        nxt      = WRITE;
      end
      WRITE: begin
        mem_write = 1'b1;
        nxt       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Request capture, load result and merged store word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        err_q   <= bad;
        wbuf_q  <= req_wdata;
        rdata_q <= 32'h0;
      end
      if (state == LOAD)   rdata_q <= ld_val;
      if (state == RMW_RD) wbuf_q  <= merged;
    end
  end

  assign mem_adr    = (mem_read | mem_write)
                    ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata  = mem_write ? wbuf_q : 32'h0;
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + random checks of
// mem_access_unit against a word-array reference model.
module tb_mem_access_unit;

  localparam int unsigned AW  = 32;
  localparam logic [31:0] LIM = 32'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  mem_access_unit #(.ADDR_W(AW), .ADDR_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // device memory, loaded through a side port during reset
  logic [31:0] dmem [0:16383];
  logic [31:0] rmem [0:16383];
  logic        ld_en;
  logic [13:0] ld_idx;
  logic [31:0] ld_val;

  assign mem_rdata = mem_read ? dmem[mem_adr[15:2]] : 32'h0;

  always @(posedge clk) begin
    if (ld_en)          dmem[ld_idx] <= ld_val;
    else if (mem_write) dmem[mem_adr[15:2]] <= mem_wdata;
  end

  int n_resp = 0;
  int n_both = 0;
  int exp_resp = 0;

  always @(negedge clk) begin
    if (resp_valid) n_resp++;
    if (mem_read && mem_write) n_both++;
  end

  // reference: plain byte-address arithmetic on a word array
  task automatic model(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd,
                       output logic err, output logic [31:0] rd,
                       output int lat, output int nrd,
                       output int nwr, output logic [31:0] ww);
    int nb, wi, sh;
    longint fin;
    logic [31:0] old, m, t;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    fin = longint'(a) + longint'(nb);
    err = (sz == 2'd3) || (sz == 2'd1 && a[0])
       || (sz == 2'd2 && a[1:0] != 2'd0)
       || (fin > longint'(LIM));
    rd = 0; ww = 0; nrd = 0; nwr = 0; lat = 1;
    if (!err) begin
      wi  = int'(a[15:2]);
      sh  = 8 * int'(a[1:0]);
      old = rmem[wi];
      if (!w) begin
        lat = 2; nrd = 1;
        t = old >> sh;
        if (nb == 1)
          rd = u ? {24'h0, t[7:0]} : {{24{t[7]}}, t[7:0]};
        else if (nb == 2)
          rd = u ? {16'h0, t[15:0]} : {{16{t[15]}}, t[15:0]};
        else
          rd = old;
      end else begin
        if (nb == 4)      m = 32'hFFFF_FFFF;
        else if (nb == 2) m = 32'h0000_FFFF << sh;
        else              m = 32'h0000_00FF << sh;
        ww = (old & ~m) | ((wd << sh) & m);
        rmem[wi] = ww;
        nwr = 1;
        nrd = (nb < 4) ? 1 : 0;
        lat = (nb < 4) ? 3 : 2;
      end
    end
  endtask

  // call at a negedge with the unit idle or in RESP;
  // returns at the negedge of the following IDLE cycle
  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold,
                        output logic [31:0] got);
    logic e_err;
    logic [31:0] e_rd, e_ww, s_ww, s_adr;
    int e_lat, e_nrd, e_nwr, lat, nrd, nwr, wt;
    bit done;
    model(w, sz, u, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr, e_ww);
    exp_resp++;
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_unsigned = u; req_addr = a; req_wdata = wd;
    wt = 0;
    while (!req_ready && wt < 8) begin
      @(negedge clk); wt++;
    end
    chk("ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    lat = 0; nrd = 0; nwr = 0; done = 0;
    s_ww = 0; s_adr = 0; got = 0;
    while (!done && lat < 8) begin
      @(negedge clk); lat++;
      if (mem_read)  begin nrd++; s_adr = mem_adr; end
      if (mem_write) begin
        nwr++; s_ww = mem_wdata; s_adr = mem_adr;
      end
      if (resp_valid) begin
        done = 1;
        got = resp_rdata;
        chk("err", 32'(resp_err), 32'(e_err));
        chk("rdata", resp_rdata, e_rd);
      end
      if (hold) req_addr = $urandom;
      else      req_valid = 1'b0;
    end
    chk("latency", lat, e_lat);
    chk("n_read", nrd, e_nrd);
    chk("n_write", nwr, e_nwr);
    if (e_nwr != 0) chk("wdata", s_ww, e_ww);
    if (e_nrd + e_nwr != 0) chk("adr", s_adr, a & 32'hFFFF_FFFC);
    @(negedge clk);
    chk("rdy_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int r, k;
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    req_valid = 0; req_write = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 14'(i); ld_val = $urandom;
      rmem[i] = ld_val;
    end
    @(negedge clk);
    ld_en = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rd", 32'(mem_read), 32'd0);
    chk("rst_wr", 32'(mem_write), 32'd0);
    chk("rst_adr", mem_adr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // word store then load
    do_req(1, 2'd2, 0, 32'h10, 32'h1122_3344, 0, got);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, got);
    chk("t1_load", got, 32'h1122_3344);
    // byte RMW store
    do_req(1, 2'd0, 0, 32'h11, 32'hDEAD_BEAB, 0, got);
    chk("t2_mem", dmem[4], 32'h1122_AB44);
    // extension
    do_req(1, 2'd2, 0, 32'h0, 32'h0000_8000, 0, got);
    do_req(0, 2'd0, 0, 32'h1, 32'h0, 0, got);
    chk("t3_sb", got, 32'hFFFF_FF80);
    do_req(0, 2'd0, 1, 32'h1, 32'h0, 0, got);
    chk("t3_ub", got, 32'h0000_0080);
    do_req(0, 2'd1, 0, 32'h0, 32'h0, 0, got);
    chk("t3_sh", got, 32'hFFFF_8000);
    // errors
    do_req(1, 2'd1, 0, 32'h13, 32'h5555_5555, 0, got);
    do_req(0, 2'd2, 0, 32'h12, 32'h0, 0, got);
    do_req(0, 2'd3, 0, 32'h0, 32'h0, 0, got);
    do_req(0, 2'd2, 0, LIM, 32'h0, 0, got);
    chk("t4_rd", got, 32'h0);
    // busy with held, changing request
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 1, got);
    do_req(0, 2'd1, 1, 32'h12, 32'h0, 0, got);
    chk("t6_next", got, 32'h0000_1122);

    // reset while in WRITE
    do_req(1, 2'd2, 0, 32'h20, 32'h1122_3344, 0, got);
    req_valid = 1; req_write = 1; req_size = 2'd0;
    req_addr = 32'h21; req_wdata = 32'h0000_00CD;
    @(posedge clk);
    k = 0;
    @(negedge clk);
    req_valid = 0;
    while (!mem_write && k < 6) begin
      @(negedge clk); k++;
    end
    chk("t5_inwr", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_wrlow", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_mem", dmem[8], 32'h1122_3344);
    chk("t5_ready", 32'(req_ready), 32'd1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 255));
      else if (r < 9) a = LIM - 32'd8 + 32'($urandom_range(0, 15));
      else            a = $urandom;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom,
             ($urandom_range(0, 9) == 0), got);
    end
    req_valid = 0;
    repeat (4) @(negedge clk);
    chk("n_resp", n_resp, exp_resp);
    chk("rd_wr_overlap", n_both, 32'd0);
    for (int i = 0; i < 64; i++)
      chk("mem_final", dmem[i], rmem[i]);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
